// File: rtl/level_spawn_scheduler.sv
// Level tracker and one-at-a-time ball spawn scheduler (req/ack to balls).
// Define LEVEL_BREATHER_EN to suppress spawns for a few ticks after level-up.
module level_spawn_scheduler #(
  parameter int NUM_BALLS      = 3,
  parameter int NUM_LEVELS     = 12,
  parameter int LEVEL_STEP     = 10,
  parameter int SCORE_W        = 16,
  parameter int MAX_SIZE       = 3,
  parameter int ACK_TIMEOUT    = 4,
  parameter int BREATHER_TICKS = 2
)(
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              enable,
  input  logic [SCORE_W-1:0]                score,
  input  logic                              secClk,
  input  logic [NUM_BALLS-1:0]              ballInUse,
  output logic [NUM_BALLS-1:0]              spawnReq,
  output logic [1:0]                        spawnSize,
  output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
  output logic                              levelUp
);

  localparam int LW = $clog2(NUM_LEVELS+1);
  localparam int QW = $clog2(NUM_BALLS+1);
  localparam int TW = $clog2(ACK_TIMEOUT+1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PLAY     = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  logic [1:0]           state;
  logic                 sec_d;
  logic                 tick;
  logic [SCORE_W-1:0]   next_thr;
  logic [SCORE_W-1:0]   step;
  logic [QW-1:0]        quota;
  logic [1:0]           size;
  logic [TW-1:0]        tmo;
  logic                 up;
  logic                 dn;
  logic                 hold;
  logic                 found;
  logic                 ack;
  logic [NUM_BALLS-1:0] pick;

  assign step = SCORE_W'(LEVEL_STEP);

  assign up = (state != IDLE)
           && (score > next_thr)
           && (level < LW'(NUM_LEVELS));

  assign dn = (state != IDLE)
           && (score <= next_thr - step)
           && (level > LW'(1));

  assign ack = |(ballInUse & spawnReq);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sec_d <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sec_d <= secClk;
      tick  <= secClk & ~sec_d;
    end
  end

  // Lowest free slot below the current quota
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (!found && (QW'(i) < quota) && !ballInUse[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level    <= '0;
      next_thr <= '0;
      quota    <= '0;
      size     <= '0;
      levelUp  <= 1'b0;
    end else if (!enable) begin
      level    <= '0;
      next_thr <= '0;
      quota    <= '0;
      size     <= '0;
      levelUp  <= 1'b0;
    end else if (state == IDLE) begin
      level    <= LW'(1);
      next_thr <= step;
      quota    <= QW'(1);
      size     <= '0;
      levelUp  <= 1'b0;
    end else begin
      levelUp <= up;
      if (up) begin
        level    <= level + LW'(1);
        next_thr <= next_thr + step;
        if (quota < QW'(NUM_BALLS)) begin
          quota <= quota + QW'(1);
        end else begin
          quota <= QW'(1);
          if (size < 2'(MAX_SIZE))
            size <= size + 2'd1;
        end
      end else if (dn) begin
        level    <= level - LW'(1);
        next_thr <= next_thr - step;
        if (quota > QW'(1)) begin
          quota <= quota - QW'(1);
        end else begin
          quota <= QW'(NUM_BALLS);
          if (size != 2'd0)
            size <= size - 2'd1;
        end
      end
    end
  end

`ifdef LEVEL_BREATHER_EN
  localparam int BW = $clog2(BREATHER_TICKS+1);

  logic [BW-1:0] brk;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      brk <= '0;
    end else if (!enable || state == IDLE) begin
      brk <= '0;
    end else if (up) begin
      brk <= BW'(BREATHER_TICKS);
    end else if (state == PLAY && tick && hold) begin
      brk <= brk - BW'(1);
    end
  end

  assign hold = (brk != '0);
`else
  logic unused_brk;

  assign unused_brk = ^BREATHER_TICKS;
  assign hold       = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      spawnReq  <= '0;
      spawnSize <= '0;
      tmo       <= '0;
    end else if (!enable) begin
      state     <= IDLE;
      spawnReq  <= '0;
      spawnSize <= '0;
      tmo       <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          state <= PLAY;
        end
        state == PLAY: begin
          if (tick && !hold && found) begin
            spawnReq  <= pick;
            spawnSize <= size;
            tmo       <= '0;
            state     <= WAIT_ACK;
          end
        end
        state == WAIT_ACK: begin
          if (ack) begin
            spawnReq  <= '0;
            spawnSize <= '0;
            state     <= PLAY;
          end else if (tick) begin
            if (tmo == TW'(ACK_TIMEOUT-1)) begin
              spawnReq  <= '0;
              spawnSize <= '0;
              tmo       <= '0;
              state     <= PLAY;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          spawnReq <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_spawn_scheduler.sv
// Bench for level_spawn_scheduler: directed steps plus random traffic
// compared cycle by cycle against a level/quota arithmetic model.
module tb_level_spawn_scheduler;

  localparam int NB   = 3;
  localparam int NL   = 12;
  localparam int STEP = 10;
  localparam int SW   = 16;
  localparam int MAXS = 3;
  localparam int TMO  = 4;
  localparam int BRK  = 2;
  localparam int LW   = $clog2(NL+1);

  logic          clk = 1'b0;
  logic          resetN;
  logic          enable;
  logic [SW-1:0] score;
  logic          secClk;
  logic [NB-1:0] ballInUse;
  logic [NB-1:0] spawnReq;
  logic [1:0]    spawnSize;
  logic [LW-1:0] level;
  logic          levelUp;

  int checks   = 0;
  int failures = 0;

  int m_st;
  int m_lvl;
  int m_req;
  int m_size;
  int m_tmo;
  int m_brk;
  bit m_tick;
  bit m_sec_d;
  bit m_lu;

  always #5 clk = ~clk;

  level_spawn_scheduler #(
    .NUM_BALLS(NB), .NUM_LEVELS(NL), .LEVEL_STEP(STEP),
    .SCORE_W(SW), .MAX_SIZE(MAXS), .ACK_TIMEOUT(TMO),
    .BREATHER_TICKS(BRK)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable),
    .score(score), .secClk(secClk), .ballInUse(ballInUse),
    .spawnReq(spawnReq), .spawnSize(spawnSize),
    .level(level), .levelUp(levelUp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int quota_of(input int l);
    return ((l - 1) % NB) + 1;
  endfunction

  function automatic int size_of(input int l);
    int s;
    s = (l - 1) / NB;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lvl = 0; m_req = -1; m_size = 0;
    m_tmo = 0; m_brk = 0; m_tick = 0; m_sec_d = 0; m_lu = 0;
  endtask

  task automatic model_step();
    int st_n, lvl_n, req_n, size_n, tmo_n, brk_n, q, s;
    bit lu_n, got;
    st_n = m_st; lvl_n = m_lvl; req_n = m_req; size_n = m_size;
    tmo_n = m_tmo; brk_n = m_brk; lu_n = 0;
    if (!enable) begin
      st_n = 0; lvl_n = 0; req_n = -1; tmo_n = 0; brk_n = 0;
    end else if (m_st == 0) begin
      st_n = 1; lvl_n = 1;
    end else begin
      q = quota_of(m_lvl);
      s = size_of(m_lvl);
      if (m_st == 1 && m_tick) begin
        if (brk_n > 0) begin
          brk_n--;
        end else begin
          got = 0;
          for (int i = 0; i < q; i++) begin
            if (!got && !ballInUse[i]) begin
              got = 1; req_n = i; size_n = s; st_n = 2; tmo_n = 0;
            end
          end
        end
      end else if (m_st == 2) begin
        if (ballInUse[m_req]) begin
          req_n = -1; st_n = 1;
        end else if (m_tick) begin
          tmo_n++;
          if (tmo_n == TMO) begin
            req_n = -1; st_n = 1; tmo_n = 0;
          end
        end
      end
      if (score > m_lvl * STEP && m_lvl < NL) begin
        lvl_n = m_lvl + 1;
        lu_n  = 1;
`ifdef LEVEL_BREATHER_EN
        brk_n = BRK;
`endif
      end else if (score <= (m_lvl - 1) * STEP && m_lvl > 1) begin
        lvl_n = m_lvl - 1;
      end
    end
    m_tick  = secClk & ~m_sec_d;
    m_sec_d = secClk;
    m_st = st_n; m_lvl = lvl_n; m_req = req_n; m_size = size_n;
    m_tmo = tmo_n; m_brk = brk_n; m_lu = lu_n;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!resetN) model_reset();
    else model_step();
    #1;
    chk("m_req", spawnReq, (m_req < 0) ? 0 : (1 << m_req));
    chk("m_level", level, m_lvl);
    chk("m_levelUp", levelUp, m_lu);
    if (m_req >= 0) chk("m_size", spawnSize, m_size);
  endtask

  task automatic tick_now();
    secClk = 1'b1;
    cyc();
    secClk = 1'b0;
    cyc();
  endtask

  task automatic drain_breather();
`ifdef LEVEL_BREATHER_EN
    for (int k = 0; k < BRK; k++) begin
      tick_now();
      chk("breather_hold", spawnReq, 0);
    end
`endif
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; score = '0;
    secClk = 1'b0; ballInUse = '0;
    model_reset();
    #12;
    chk("rst_req", spawnReq, 0);
    chk("rst_size", spawnSize, 0);
    chk("rst_level", level, 0);
    chk("rst_levelUp", levelUp, 0);
    resetN = 1'b1;

    enable = 1'b1;
    cyc();
    chk("enter_level", level, 1);
    tick_now();
    chk("first_req", spawnReq, 3'b001);
    chk("first_size", spawnSize, 0);
    ballInUse = 3'b001;
    cyc();
    chk("first_ack", spawnReq, 0);

    score = 45; ballInUse = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("jump_levelUp", levelUp, 1);
      chk("jump_level", level, 2 + k);
    end
    cyc();
    chk("jump_done_lu", levelUp, 0);
    chk("jump_done_lvl", level, 5);
    drain_breather();
    tick_now();
    chk("l5_req0", spawnReq, 3'b001);
    chk("l5_size0", spawnSize, 1);
    ballInUse = 3'b001;
    cyc();
    tick_now();
    chk("l5_req1", spawnReq, 3'b010);
    chk("l5_size1", spawnSize, 1);
    ballInUse = 3'b011;
    cyc();
    chk("l5_ack1", spawnReq, 0);

    score = 115;
    for (int k = 0; k < 7; k++) cyc();
    chk("l12_level", level, 12);
    drain_breather();
    tick_now();
    chk("l12_req", spawnReq, 3'b100);
    chk("l12_size", spawnSize, 3);
    tick_now();
    chk("l12_no_second", spawnReq, 3'b100);

    ballInUse = 3'b111;
    cyc();
    ballInUse = 3'b000;
    tick_now();
    chk("tmo_req", spawnReq, 3'b001);
    for (int k = 0; k < TMO - 1; k++) begin
      tick_now();
      chk("tmo_held", spawnReq, 3'b001);
    end
    tick_now();
    chk("tmo_drop", spawnReq, 0);
    tick_now();
    chk("tmo_rereq", spawnReq, 3'b001);

    ballInUse = 3'b001;
    cyc();
    tick_now();
    chk("dis_req", spawnReq, 3'b010);
    enable = 1'b0;
    cyc();
    chk("dis_req0", spawnReq, 0);
    chk("dis_level0", level, 0);
    enable = 1'b1;
    cyc();
    chk("reen_level", level, 1);

    score = 0; ballInUse = '0;
    cyc();
    tick_now();
    chk("rst_mid_req", spawnReq, 3'b001);
    #2 resetN = 1'b0;
    #1;
    chk("rst_mid_req0", spawnReq, 0);
    chk("rst_mid_lvl0", level, 0);
    model_reset();
    #3 resetN = 1'b1;
    cyc();
    chk("post_rst_lvl", level, 1);

    score = 11;
    cyc();
    chk("cross10_lu", levelUp, 1);
    drain_breather();
    tick_now();
    chk("cross10_req", spawnReq, 3'b001);
    chk("cross10_size", spawnSize, 0);
    ballInUse = 3'b001;
    cyc();

    for (int n = 0; n < 3000; n++) begin
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      case ($urandom_range(0, 15))
        0: score = SW'($urandom_range(0, 130));
        1: if (score < 130) score = score + 1'b1;
        2: if (score > 0) score = score - 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) secClk = ~secClk;
      if ($urandom_range(0, 9) == 0)
        ballInUse[$urandom_range(0, NB - 1)] = 1'b0;
      if (m_req >= 0 && $urandom_range(0, 19) == 0)
        ballInUse[m_req] = 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
